// File: rtl/sa_pkg.sv
// Shared systolic-array constants and types.
// Used by the edge feeders and the PE array.
package sa_pkg;

  localparam int SA_N         = 4;
  localparam int SA_OPERAND_W = 8;
  localparam int SA_PSUM_W    = 16;

  typedef logic [SA_OPERAND_W-1:0] operand_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register of {valid, data}.
// Advances every cycle; the array has no backpressure.
module skew_delay_line #(
  parameter int DEPTH_p = 1,
  parameter int WIDTH_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               v_i,
  input  logic [WIDTH_p-1:0] data_i,
  output logic               v_o,
  output logic [WIDTH_p-1:0] data_o
);

  logic [DEPTH_p-1:0] r_v;
  logic [WIDTH_p-1:0] r_d [DEPTH_p];

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH_p; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      r_v[0] <= v_i;
      r_d[0] <= data_i;
      for (int k = 1; k < DEPTH_p; k++) begin
        r_v[k] <= r_v[k-1];
        r_d[k] <= r_d[k-1];
      end
    end
  end

  assign v_o    = r_v[DEPTH_p-1];
  assign data_o = r_d[DEPTH_p-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// Skews an N-lane operand vector into a diagonal wavefront
// for the systolic array edge, then drains with zero bubbles.
module operand_skew_feeder
  import sa_pkg::*;
#(
  parameter int N_p     = SA_N,
  parameter int WIDTH_p = SA_OPERAND_W
) (
  input  logic                   clk_i,
  input  logic                   reset_n,
  input  logic                   v_i,
  input  logic [N_p*WIDTH_p-1:0] data_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [N_p*WIDTH_p-1:0] data_o,
  output logic [N_p-1:0]         v_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int CW = (N_p > 1) ? $clog2(N_p) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_p - 1);

  feeder_state_e r_state;
  feeder_state_e w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic          r_alive;
  logic          w_acc;
  logic          w_done;
  logic [N_p*WIDTH_p-1:0] w_in;

  // r_alive keeps ready low until the first clock after reset release
  assign ready_o = r_alive & (r_state != DRAIN);
  assign w_acc   = v_i & ready_o;
  assign busy_o  = (r_state != IDLE);
  assign done_o  = w_done;
  assign w_in    = w_acc ? data_i : '0;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_alive <= 1'b1;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE, STREAM: begin
        if (w_acc) begin
          if (last_i) begin
            w_nstate = DRAIN;
            w_ncnt   = CNT_LOAD;
          end else begin
            w_nstate = STREAM;
          end
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_done   = 1'b1;
          w_nstate = IDLE;
        end else begin
          w_ncnt = r_cnt - 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_p; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH_p(i + 1),
      .WIDTH_p(WIDTH_p)
    ) u_dl (
      .clk_i  (clk_i),
      .reset_n(reset_n),
      .v_i    (w_acc),
      .data_i (w_in[i*WIDTH_p +: WIDTH_p]),
      .v_o    (v_o[i]),
      .data_o (data_o[i*WIDTH_p +: WIDTH_p])
    );
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Scoreboard bench for operand_skew_feeder.
// Stimulus pushes per-lane expectations; a negedge monitor pops them.
module tb_operand_skew_feeder;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         stamp;
    logic [W-1:0] d;
  } exp_t;

  typedef enum {M_IDLE, M_STREAM, M_DRAIN} mst_e;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           v_i = 1'b0;
  logic           last_i = 1'b0;
  logic [N*W-1:0] data_i = '0;
  logic           ready_o;
  logic [N*W-1:0] data_o;
  logic [N-1:0]   v_o;
  logic           busy_o;
  logic           done_o;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   vcnt [N];
  exp_t lq [N][$];
  int   dq [$];
  mst_e mstate = M_IDLE;
  int   mcnt = 0;
  bit   malive = 1'b0;

  operand_skew_feeder #(.N_p(N), .WIDTH_p(W)) dut (
    .clk_i  (clk),
    .reset_n(rst_n),
    .v_i    (v_i),
    .data_i (data_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .v_o    (v_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s at cyc %0d", nm, cyc);
  endtask

  task automatic step(input bit v, input logic [N*W-1:0] d,
                      input bit l);
    bit   rdy;
    bit   acc;
    exp_t e;
    v_i    = v;
    data_i = d;
    last_i = l;
    rdy = malive && (mstate != M_DRAIN);
    acc = v && rdy;
    #1;
    chk("ready", ready_o, rdy);
    chk("busy", busy_o, mstate != M_IDLE);
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        e.stamp = cyc + 1 + i;
        e.d     = d[i*W +: W];
        lq[i].push_back(e);
      end
      if (l) dq.push_back(cyc + N);
    end
    @(posedge clk);
    #1;
    malive = 1'b1;
    case (mstate)
      M_IDLE, M_STREAM: begin
        if (acc) begin
          if (l) begin
            mstate = M_DRAIN;
            mcnt   = N - 1;
          end else begin
            mstate = M_STREAM;
          end
        end
      end
      default: begin
        if (mcnt == 0) mstate = M_IDLE;
        else mcnt--;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_v_o", v_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_ready", ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
    end else begin
      if (busy_o) busy_cnt++;
      for (int i = 0; i < N; i++) begin
        while (lq[i].size() > 0 && lq[i][0].stamp < cyc) begin
          flag($sformatf("missed_lane%0d", i));
          void'(lq[i].pop_front());
        end
        if (v_o[i]) begin
          vcnt[i]++;
          if (lq[i].size() == 0) begin
            flag($sformatf("unexpected_lane%0d", i));
          end else begin
            exp_t e;
            e = lq[i].pop_front();
            chk($sformatf("lane%0d_cycle", i), cyc, e.stamp);
            chk($sformatf("lane%0d_data", i), data_o[i*W +: W], e.d);
          end
        end else begin
          chk($sformatf("lane%0d_bubble", i), data_o[i*W +: W], 0);
        end
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        flag("missed_done");
        void'(dq.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        if (dq.size() == 0) flag("unexpected_done");
        else chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic mid_reset();
    rst_n = 1'b0;
    v_i   = 1'b0;
    #1;
    chk("mrst_v_o", v_o, 0);
    chk("mrst_done", done_o, 0);
    chk("mrst_ready", ready_o, 0);
    for (int i = 0; i < N; i++) lq[i].delete();
    dq.delete();
    mstate = M_IDLE;
    mcnt   = 0;
    malive = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < N; i++) vcnt[i] = 0;
    #2;
    rst_n  = 1'b0;
    v_i    = 1'b1;
    data_i = 32'h04030201;
    @(posedge clk);
    #1;
    chk("init_data_o", data_o, 0);
    chk("init_v_o", v_o, 0);
    chk("init_ready", ready_o, 0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    step(1'b1, 32'h04030201, 1'b0);
    step(1'b0, '0, 1'b0);

    // single vector, last
    step(1'b1, 32'h04030201, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0);

    // stream with a bubble
    step(1'b1, 32'h11111111, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 32'h22222222, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0);

    // held vector during drain
    step(1'b1, 32'h33333333, 1'b1);
    repeat (5) step(1'b1, 32'h55555555, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0);

    // reset one cycle into drain
    step(1'b1, 32'h77777777, 1'b1);
    mid_reset();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // eight back-to-back vectors
    for (int i = 0; i < N; i++) vcnt[i] = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      b = k[7:0];
      step(1'b1, {b + 8'h40, b + 8'h30, b + 8'h20, b + 8'h10}, k == 7);
    end
    repeat (5) step(1'b0, '0, 1'b0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("cont_slots_lane%0d", i), vcnt[i], 8);
    end
    chk("cont_done_count", done_cnt, 1);
    chk("cont_busy_cycles", busy_cnt, 11);

    for (int i = 0; i < N; i++) begin
      chk($sformatf("left_lane%0d", i), lq[i].size(), 0);
    end
    chk("left_done", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
Name: operand_skew_feeder

Overview:
- Edge feeder that sits directly upstream of the PE array. It sits on the west edge for A operands; a second instance on the north edge handles B.
- Accepts one N-lane operand vector per cycle over valid/ready. Each lane is delayed so that lane i reaches the array i cycles after lane 0, producing the diagonal wavefront the systolic PEs require.
- After the last vector of a tile, it drains the delay lines by injecting zero operands.

Parameters:
- N_p, 4, number of lanes (array rows or columns); must be >= 2.
- WIDTH_p, 8, operand width; matches the PE A/B operand width.

Ports:
- clk_i  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- v_i  input  1  input vector valid.
- data_i  input  N_p*WIDTH_p  operand vector; lane i occupies bits [i*WIDTH_p +: WIDTH_p].
- last_i  input  1  qualifies v_i: this vector is the last one of the tile.
- ready_o  output  1  feeder can accept a vector this cycle.
- data_o  output  N_p*WIDTH_p  skewed operands to the array edge, same lane packing.
- v_o  output  N_p  per-lane valid of data_o.
- busy_o  output  1  asserted in STREAM or DRAIN.
- done_o  output  1  single-cycle pulse when the drain completes.

Behaviour:
- Reset:
  - Asserting reset_n low immediately clears state to IDLE, all delay-line stages to zero/invalid, and the drain counter.
  - During reset, data_o=0, v_o=0, busy_o=0, done_o=0, ready_o=0.
  - Deassertion is sampled synchronously. ready_o becomes 1 on the first clock after release.
- Accept rule: a vector is accepted on a rising edge where v_i & ready_o.
- Lane latency: lane i output is registered with latency i+1 cycles from acceptance.
  - Lane i uses an (i+1)-deep shift register of {valid, data}.
  - Vector accepted at edge t appears on lane 0 after edge t, and on lane i after edge t+i.
- The downstream PE array has no backpressure, so the delay lines advance every cycle unconditionally.
- Cycle with no accept (v_i=0 in IDLE/STREAM, or any DRAIN cycle): a bubble with valid=0 and data=0 enters every lane.
- Invalid output slots always drive data=0, so a PE multiply yields 0 and leaves partial sums unchanged.
- State machine:
  - IDLE: ready_o=1, busy_o=0. An accept with last_i=0 goes to STREAM. An accept with last_i=1 goes to DRAIN.
  - STREAM: ready_o=1, busy_o=1. Bubbles are permitted. An accept with last_i=1 goes to DRAIN. Otherwise it stays in STREAM.
  - DRAIN: ready_o=0, busy_o=1. The drain counter loads N_p-1 on entry and decrements each cycle. At 0 the block pulses done_o for one cycle and returns to IDLE.
  - Consequence: done_o asserts in the same cycle the last vector's lane N_p-1 element is presented on data_o.
- ready_o depends only on state (Moore). No combinational path exists from v_i to ready_o.
- v_i while ready_o=0 is ignored; the upstream must hold its vector.
- last_i is ignored unless v_i & ready_o.
- Back-to-back tiles: the earliest next accept is the cycle after done_o, once the block is back in IDLE. Throughput is 1 vector/cycle within a tile. The gap between tiles is N_p cycles.
- A reset assertion mid-STREAM or mid-DRAIN discards all in-flight operands. No done_o is produced.
- Data widths pass through unmodified; the block performs no arithmetic on operands.

Decomposition:
- Shared package sa_pkg holds:
  - constants SA_N and SA_OPERAND_W (8) and SA_PSUM_W (16);
  - typedef operand_t (logic [SA_OPERAND_W-1:0]);
  - enum feeder_state_e {IDLE, STREAM, DRAIN}.
- One natural sub-module: skew_delay_line, parameterised by DEPTH_p and WIDTH_p. It is an async-active-low-reset shift register of {valid, data}, generated once per lane with DEPTH_p = i+1.
- The FSM and drain counter live in the top module.

Test Plan:
- Reset: hold reset_n=0 mid-cycle with v_i=1 and data_i=0x04030201 -> data_o=0, v_o=0, ready_o=0. After release, ready_o=1 on the next edge.
- Single vector: accept 0x04030201 with last_i=1 at edge t -> lane0=0x01 valid after t, lane1=0x02 after t+1, lane2=0x03 after t+2, lane3=0x04 after t+3. done_o pulses at t+3. ready_o=0 over t+1..t+3.
- Stream with bubble: accept vectors 0x11 (all lanes), then a v_i=0 cycle, then 0x22 with last_i=1 -> lane3 shows 0x11, then 0/invalid, then 0x22 on consecutive cycles. done_o pulses with 0x22 on lane3.
- Backpressure: drive v_i=1 with 0x55 during DRAIN -> not accepted, no output change. It is accepted on the first cycle after done_o and appears on lane0 one cycle later.
- Reset mid-DRAIN: assert reset_n=0 one cycle after the last accept -> all v_o=0 immediately, no done_o. The block returns to IDLE after release.
- Continuous: 8 vectors back-to-back, last on the 8th -> exactly 8 valid slots per lane, no gaps, done_o once, busy_o high for 8+3 cycles.
